pkt_rx_port: RTL and testbench

- Receive end of the byte-stream packet interface that the bench driver transmits into `dut_top`.
- Accepts framed packets of the form header byte, length byte, then payload bytes.
- Validates each packet and buffers it store-and-forward in an internal FIFO.
- Presents only complete, valid packets to the switch core over a valid/ready stream. Malformed packets are discarded without trace on the output side.

---
 rtl/pkt_rx_pkg.sv | 23 ++
 rtl/pkt_desc_fifo.sv | 51 +++++
 rtl/pkt_rx_port.sv | 210 +++++++++++++++++++++
 tb/tb_pkt_rx_port.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_rx_pkg.sv
// Shared types and constants for the packet receive port.
package pkt_rx_pkg;

  localparam int HDR_BYTES     = 2;
  localparam int DROP_CNT_W    = 16;
  localparam int DESC_DEPTH    = 4;
  localparam int NUM_PORTS_DEF = 4;
  localparam int DEST_W        = $clog2(NUM_PORTS_DEF);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LEN     = 2'd1,
    PAYLOAD = 2'd2,
    DROP    = 2'd3
  } rx_state_e;

  // One committed packet: where it goes and how many payload bytes it has.
  typedef struct packed {
    logic [DEST_W-1:0] dest;
    logic [7:0]        len;
  } pkt_desc_t;

endpackage

// File: rtl/pkt_desc_fifo.sv
// Small synchronous FIFO of packet descriptors. Besides the head entry it
// also exposes the entry behind the head, so the output side can start the
// next packet in the same cycle the current packet's last byte is taken.
module pkt_desc_fifo
  import pkt_rx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  pkt_desc_t              push_desc,
  input  logic                   pop,
  output pkt_desc_t              head,
  output pkt_desc_t              next_head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  pkt_desc_t       mem [DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic [AW-1:0]   rd_next;

  assign rd_next   = rd_ptr[AW-1:0] + 1'b1;
  assign count     = wr_ptr - rd_ptr;
  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign head      = mem[rd_ptr[AW-1:0]];
  assign next_head = mem[rd_next];

  // Pointer update; push is ignored when full, pop when empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Descriptor storage, not reset.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_desc;
  end

endmodule

// File: rtl/pkt_rx_port.sv
// Receive port: parses header/length/payload frames, buffers payload
// store-and-forward with commit/rollback pointers, and streams out only
// complete valid packets.
//
// Handshake rule on both sides: a byte moves on a rising clk edge where
// valid && ready are both high; the sender holds valid and its data/last/
// dest fields unchanged until that edge; ready may depend on the offered
// data (the length byte stall) but valid never depends on ready.
module pkt_rx_port
  import pkt_rx_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int DEPTH     = 64,
  parameter int MAX_LEN   = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [7:0]                   in_data,
  input  logic                         in_last,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [7:0]                   out_data,
  output logic                         out_last,
  output logic [$clog2(NUM_PORTS)-1:0] out_dest,
  input  logic                         out_ready,
  output logic                         err_pulse,
  output logic [DROP_CNT_W-1:0]        drop_count,
  output rx_state_e                    dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Input side state
  rx_state_e         state_q, state_d;
  logic [DEST_W-1:0] dest_q;
  logic [7:0]        len_q;
  logic [7:0]        rem_q;
  logic              bad_q;

  // Byte buffer: wr_ptr runs ahead with uncommitted bytes, cmt_ptr marks the
  // end of the last good packet, rd_ptr is the next byte to load for output.
  logic [PW-1:0]     wr_ptr, cmt_ptr, rd_ptr;
  logic [7:0]        buf_mem [DEPTH];

  logic              accept, rdy, len_ok, too_big;
  logic              wr_en, commit, drop_evt;
  logic [PW-1:0]     used;
  logic [8:0]        free_sp;

  // Descriptor queue
  pkt_desc_t         push_desc, head, next_head, sel;
  logic [$clog2(DESC_DEPTH):0] desc_cnt;
  logic              desc_full, desc_empty;

  // Output side
  logic [7:0]        byte_idx;
  logic              sel_avail, load, pop, last_byte;

  assign used      = wr_ptr - rd_ptr;
  assign free_sp   = 9'(DEPTH) - 9'(used);
  assign len_ok    = (in_data != 8'd0) && (in_data <= 8'(MAX_LEN)) && !bad_q;
  assign too_big   = {1'b0, in_data} > free_sp;
  assign in_ready  = rdy && !reset;
  assign accept    = in_valid && in_ready;
  assign dbg_state = state_q;
  assign push_desc = '{dest: dest_q, len: len_q};

  // Input FSM: next state, ready, and the write/commit/drop strobes.
  always_comb begin
    state_d  = state_q;
    rdy      = 1'b0;
    wr_en    = 1'b0;
    commit   = 1'b0;
    drop_evt = 1'b0;
    case (state_q)
      IDLE: begin
        rdy = !desc_full;
        if (accept) begin
          if (in_last) drop_evt = 1'b1;
          else         state_d  = LEN;
        end
      end
      LEN: begin
        // Stall a good length that does not fit yet; bad lengths never stall.
        rdy = !(len_ok && !in_last && too_big);
        if (accept) begin
          if (!len_ok || in_last) begin
            drop_evt = 1'b1;
            state_d  = in_last ? IDLE : DROP;
          end else begin
            state_d  = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        rdy = 1'b1;
        if (accept) begin
          wr_en = 1'b1;
          if (rem_q == 8'd1) begin
            if (in_last) begin
              commit  = 1'b1;
              state_d = IDLE;
            end else begin
              drop_evt = 1'b1;
              state_d  = DROP;
            end
          end else if (in_last) begin
            drop_evt = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      DROP: begin
        rdy = 1'b1;
        if (accept && in_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Input state register, header/length capture, pointers and drop stats.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      dest_q     <= '0;
      len_q      <= '0;
      rem_q      <= '0;
      bad_q      <= 1'b0;
      wr_ptr     <= '0;
      cmt_ptr    <= '0;
      err_pulse  <= 1'b0;
      drop_count <= '0;
    end else begin
      state_q   <= state_d;
      err_pulse <= drop_evt;
      if (drop_evt && (drop_count != '1)) drop_count <= drop_count + 1'b1;
      if (state_q == IDLE && accept) begin
        dest_q <= in_data[DEST_W-1:0];
        bad_q  <= (in_data >= 8'(NUM_PORTS));
      end
      if (state_q == LEN && accept) begin
        len_q <= in_data;
        rem_q <= in_data;
      end
      if (wr_en) rem_q <= rem_q - 8'd1;
      if (drop_evt)   wr_ptr <= cmt_ptr;
      else if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (commit) cmt_ptr <= wr_ptr + 1'b1;
    end
  end

  // Payload byte storage, not reset.
  always_ff @(posedge clk) begin
    if (wr_en) buf_mem[wr_ptr[AW-1:0]] <= in_data;
  end

  pkt_desc_fifo #(.DEPTH(DESC_DEPTH)) u_desc_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (commit),
    .push_desc (push_desc),
    .pop       (pop),
    .head      (head),
    .next_head (next_head),
    .count     (desc_cnt),
    .full      (desc_full),
    .empty     (desc_empty)
  );

  // Pick which packet the next loaded byte belongs to: while the output
  // register holds a last byte, the head is still that packet, so look one
  // entry further to keep packets back-to-back.
  always_comb begin
    if (out_valid && out_last) begin
      sel       = next_head;
      sel_avail = (desc_cnt >= 3'd2);
    end else begin
      sel       = head;
      sel_avail = !desc_empty;
    end
    load      = (!out_valid || out_ready) && sel_avail;
    last_byte = ((byte_idx + 8'd1) == sel.len);
    pop       = out_valid && out_ready && out_last;
  end

  // Registered output stage, refilled whenever it is empty or being taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_dest  <= '0;
      rd_ptr    <= '0;
      byte_idx  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= buf_mem[rd_ptr[AW-1:0]];
      out_last  <= last_byte;
      out_dest  <= sel.dest;
      rd_ptr    <= rd_ptr + 1'b1;
      byte_idx  <= last_byte ? 8'd0 : byte_idx + 8'd1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pkt_rx_port.sv
// Bench for pkt_rx_port: directed table of frames, hand-written corner
// sequences, and random frames checked against a frame-level model.
module tb_pkt_rx_port;
  import pkt_rx_pkg::*;

  localparam int NP  = 4;
  localparam int DEP = 64;
  localparam int ML  = 32;

  typedef logic [7:0] byte_q_t [$];

  typedef struct {
    logic [7:0] hdr;
    logic [7:0] len;
    int         npay;
    bit         hdr_only;
    bit         exp_drop;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic [1:0]  out_dest;
  logic        out_ready = 1'b0;
  logic        err_pulse;
  logic [15:0] drop_count;
  rx_state_e   dbg_state;

  logic [10:0] exp_q [$];
  int          n_pass = 0;
  int          n_total = 0;
  int          err_cnt = 0;
  int          exp_drops = 0;
  bit          rand_rdy = 1'b0;
  bit          ready_fix = 1'b0;

  pkt_rx_port #(.NUM_PORTS(NP), .DEPTH(DEP), .MAX_LEN(ML)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_dest   (out_dest),
    .out_ready  (out_ready),
    .err_pulse  (err_pulse),
    .drop_count (drop_count),
    .dbg_state  (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Sink ready: fixed level or random per cycle.
  always @(posedge clk) begin
    #1;
    out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : ready_fix;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  function automatic logic [10:0] ent(logic [1:0] d, logic l, logic [7:0] b);
    return {d, l, b};
  endfunction

  function automatic byte_q_t make_pkt(logic [7:0] hdr, logic [7:0] len, int npay, bit hdr_only);
    byte_q_t p;
    p.push_back(hdr);
    if (!hdr_only) begin
      p.push_back(len);
      for (int j = 0; j < npay; j++) p.push_back(8'($urandom_range(0, 255)));
    end
    return p;
  endfunction

  // Frame-level reference: a frame is delivered only if it has a legal
  // destination and a legal length and carries exactly that many bytes.
  function automatic void model_pkt(byte_q_t p);
    bit ok;
    ok = (p.size() >= 2) && (p[0] < NP) && (p[1] != 0) && (p[1] <= ML) &&
         (p.size() - 2 == int'(p[1]));
    if (ok) begin
      for (int j = 2; j < p.size(); j++)
        exp_q.push_back(ent(p[0][1:0], j == p.size() - 1, p[j]));
    end else begin
      exp_drops++;
    end
  endfunction

  // Driver: entered and left at posedge+1.
  task automatic drive_byte(input logic [7:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) $display("FAIL in_ready_timeout: got 0 expected 1");
    if (!in_ready) n_total++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_pkt(input byte_q_t p);
    for (int j = 0; j < p.size(); j++) drive_byte(p[j], j == p.size() - 1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left_over", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard and hold-stability monitor, sampled on the falling edge.
  logic        prev_v = 1'b0;
  logic        prev_r = 1'b0;
  logic [10:0] prev_w = '0;
  always @(negedge clk) begin
    if (reset) begin
      prev_v = 1'b0;
    end else begin
      if (err_pulse) err_cnt++;
      if (prev_v && !prev_r) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_fields", {out_dest, out_last, out_data}, prev_w);
      end
      if (out_valid && out_ready) begin
        chk("out_expected_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("out_byte", {out_dest, out_last, out_data}, exp_q.pop_front());
      end
      prev_v = out_valid;
      prev_r = out_ready;
      prev_w = {out_dest, out_last, out_data};
    end
  end

  vec_t    vecs [10];
  byte_q_t p, pa, pb, pc;
  int      eb;
  bit      c_done;

  initial begin
    vecs[0] = '{8'h07, 8'd2,  2,  1'b0, 1'b1};  // bad destination
    vecs[1] = '{8'h01, 8'd4,  2,  1'b0, 1'b1};  // short payload
    vecs[2] = '{8'h03, 8'd1,  1,  1'b0, 1'b0};  // one-byte packet after a drop
    vecs[3] = '{8'h00, 8'd0,  0,  1'b0, 1'b1};  // zero length, last on length
    vecs[4] = '{8'h01, 8'd33, 33, 1'b0, 1'b1};  // length above maximum
    vecs[5] = '{8'h00, 8'd32, 32, 1'b0, 1'b0};  // maximum length
    vecs[6] = '{8'h02, 8'd2,  3,  1'b0, 1'b1};  // long payload
    vecs[7] = '{8'h01, 8'd0,  0,  1'b1, 1'b1};  // header only
    vecs[8] = '{8'h04, 8'd1,  1,  1'b0, 1'b1};  // first illegal destination
    vecs[9] = '{8'h03, 8'd5,  5,  1'b0, 1'b0};  // plain good packet

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_dest", out_dest, 0);
    chk("rst_err_pulse", err_pulse, 0);
    chk("rst_drop_count", drop_count, 0);
    chk("rst_state", dbg_state, IDLE);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Basic packet and output latency
    ready_fix = 1'b1;
    p = '{8'h02, 8'd3, 8'hA1, 8'hA2, 8'hA3};
    model_pkt(p);
    send_pkt(p);
    chk("lat_not_yet_valid", out_valid, 0);
    @(posedge clk);
    #1;
    chk("lat_first_valid", out_valid, 1);
    chk("lat_first_data", out_data, 8'hA1);
    chk("lat_first_dest", out_dest, 2);
    chk("lat_first_last", out_last, 0);
    wait_drain();
    chk("t1_drop_count", drop_count, 0);

    // Directed table
    for (int i = 0; i < 10; i++) begin
      p = make_pkt(vecs[i].hdr, vecs[i].len, vecs[i].npay, vecs[i].hdr_only);
      if (!vecs[i].exp_drop) begin
        for (int j = 0; j < vecs[i].npay; j++)
          exp_q.push_back(ent(vecs[i].hdr[1:0], j == vecs[i].npay - 1, p[j+2]));
      end else begin
        exp_drops++;
      end
      eb = err_cnt;
      send_pkt(p);
      wait_drain();
      chk($sformatf("vec%0d_err_pulses", i), err_cnt - eb, {31'd0, vecs[i].exp_drop});
      chk($sformatf("vec%0d_drop_count", i), drop_count, exp_drops);
    end

    // Buffer full: two 32-byte packets fit, the third stalls at its length
    ready_fix = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    pa = make_pkt(8'h00, 8'd32, 32, 1'b0);
    pb = make_pkt(8'h01, 8'd32, 32, 1'b0);
    pc = make_pkt(8'h02, 8'd32, 32, 1'b0);
    model_pkt(pa);
    model_pkt(pb);
    model_pkt(pc);
    send_pkt(pa);
    send_pkt(pb);
    c_done = 1'b0;
    fork
      begin
        send_pkt(pc);
        c_done = 1'b1;
      end
    join_none
    repeat (8) @(negedge clk);
    chk("full_in_ready_low", in_ready, 0);
    chk("full_state_len", dbg_state, LEN);
    chk("full_out_held_valid", out_valid, 1);
    chk("full_out_held_data", out_data, pa[2]);
    @(posedge clk);
    #1;
    ready_fix = 1'b1;
    for (int n = 0; n < 6000 && !c_done; n++) @(negedge clk);
    chk("full_third_accepted", c_done, 1);
    wait_drain();
    chk("full_drop_count", drop_count, exp_drops);

    // Random sink ready on a 5-byte packet
    rand_rdy = 1'b1;
    p = make_pkt(8'h03, 8'd5, 5, 1'b0);
    model_pkt(p);
    send_pkt(p);
    wait_drain();

    // Random frames against the model
    eb = err_cnt;
    for (int k = 0; k < 30; k++) begin
      int         kind;
      int         npay;
      logic [7:0] hdr, len;
      kind = $urandom_range(0, 9);
      hdr  = (kind == 4) ? 8'($urandom_range(4, 255)) : 8'($urandom_range(0, 3));
      len  = (kind == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(1, ML));
      npay = int'(len);
      if (kind == 1) npay = npay + 1;
      if (kind == 2 && npay > 0) npay = npay - 1;
      p = make_pkt(hdr, len, npay, kind == 3);
      model_pkt(p);
      send_pkt(p);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    wait_drain();
    chk("rand_drop_count", drop_count, exp_drops);
    rand_rdy  = 1'b0;
    ready_fix = 1'b0;

    // Reset in the middle of a packet while another is being read
    repeat (2) @(posedge clk);
    #1;
    pa = make_pkt(8'h01, 8'd8, 8, 1'b0);
    model_pkt(pa);
    send_pkt(pa);
    pb = make_pkt(8'h02, 8'd6, 6, 1'b0);
    for (int j = 0; j < 4; j++) drive_byte(pb[j], 1'b0);
    ready_fix = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_state_payload", dbg_state, PAYLOAD);
    eb = err_cnt;
    reset = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    exp_drops = 0;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_last", out_last, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_out_dest", out_dest, 0);
    chk("mid_rst_err_pulse", err_pulse, 0);
    chk("mid_rst_drop_count", drop_count, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_post_in_ready", in_ready, 1);
    p = make_pkt(8'h03, 8'd4, 4, 1'b0);
    model_pkt(p);
    send_pkt(p);
    wait_drain();
    chk("mid_no_err_pulse", err_cnt - eb, 0);
    chk("mid_final_drop_count", drop_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
